// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle WIDTH-bit subtractor, DIFF = A - B - BIN.
// Processes DIGIT bits per clock, LSB digit first. The borrow is carried between
// steps in a register. Valid/ready handshakes on both the input and output sides.
// Optional feature macro: SERIAL_SUB_OVF_EN enables the two's-complement overflow
// flag. When the macro is undefined, ovf is tied low.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int MSB   = WIDTH - 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

    // Reject geometries where the digits do not tile the operand exactly.
    generate
        if (WIDTH < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("serial_subtractor: WIDTH=%0d must be >= 1 and a multiple of DIGIT=%0d",
                   WIDTH, DIGIT);
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, diff_q;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q;
    logic             bout_q;
    logic             accept;
    logic             last_step;

    logic [DIGIT-1:0] a_dig, b_dig, dig_diff;
    logic             dig_borrow;
    int               digit_base;

    assign accept    = in_valid & in_ready;
    assign last_step = (cnt_q == LAST_CNT);
    assign diff      = diff_q;
    assign bout      = bout_q;

    // Next-state and handshake outputs for the IDLE/RUN/DONE controller.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last_step) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_d = in_valid ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // One DIGIT-wide full-subtractor stage, rippling the borrow through its bits.
    always_comb begin
        digit_base = int'(cnt_q) * DIGIT;
        a_dig      = a_q[digit_base +: DIGIT];
        b_dig      = b_q[digit_base +: DIGIT];
        dig_diff   = '0;
        dig_borrow = borrow_q;
        for (int i = 0; i < DIGIT; i++) begin
            dig_diff[i] = a_dig[i] ^ b_dig[i] ^ dig_borrow;
            dig_borrow  = (~a_dig[i] & b_dig[i]) | (~(a_dig[i] ^ b_dig[i]) & dig_borrow);
        end
    end

    // State, operand capture, digit-by-digit result write and borrow carry.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, regardless of statement order.
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q      <= a;
                b_q      <= b;
                borrow_q <= bin;
                cnt_q    <= '0;
            end else if (state_q == RUN) begin
                diff_q[digit_base +: DIGIT] <= dig_diff;
                borrow_q                    <= dig_borrow;
                cnt_q                       <= last_step ? '0 : cnt_q + CW'(1);
                if (last_step) bout_q <= dig_borrow;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q;

    // Signed overflow: operands differ in sign and the result sign differs from A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && last_step) begin
            ovf_q <= (a_q[MSB] ^ b_q[MSB]) & (dig_diff[DIGIT-1] ^ a_q[MSB]);
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed plus randomized checks of serial_subtractor in four
// geometries (1x1, 8x1, 8x4, 16x1) against an arithmetic reference model.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_valid, out_ready, in_ready, out_valid, bout_v, ovf_v;
    logic [15:0] a, b;
    logic        bin;
    logic        d1;
    logic [7:0]  d8, d84;
    logic [15:0] d16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(1), .DIGIT(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0:0]), .b(b[0:0]), .bin(bin), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .diff(d1), .bout(bout_v[0]), .ovf(ovf_v[0]));

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[7:0]), .b(b[7:0]), .bin(bin), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .diff(d8), .bout(bout_v[1]), .ovf(ovf_v[1]));

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a[7:0]), .b(b[7:0]), .bin(bin), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .diff(d84), .bout(bout_v[2]), .ovf(ovf_v[2]));

    serial_subtractor #(.WIDTH(16), .DIGIT(1)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .diff(d16), .bout(bout_v[3]), .ovf(ovf_v[3]));

    function automatic int width_of(input int sel);
        case (sel)
            0:       return 1;
            1:       return 8;
            2:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int steps_of(input int sel);
        case (sel)
            0:       return 1;
            1:       return 8;
            2:       return 2;
            default: return 16;
        endcase
    endfunction

    function automatic logic [15:0] get_diff(input int sel);
        case (sel)
            0:       return 16'(d1);
            1:       return 16'(d8);
            2:       return 16'(d84);
            default: return d16;
        endcase
    endfunction

    // Reference: {ovf, bout, diff} from plain integer arithmetic on w-bit operands.
    function automatic logic [17:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                          input logic z);
        longint mask, half, ux, uy, r, sx, sy, sr;
        logic   o;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ux   = longint'(x) & mask;
        uy   = longint'(y) & mask;
        r    = ux - uy - longint'(z);
        sx   = (ux >= half) ? ux - (mask + 1) : ux;
        sy   = (uy >= half) ? uy - (mask + 1) : uy;
        sr   = sx - sy - longint'(z);
        o    = (sr < -half) || (sr >= half);
`ifndef SERIAL_SUB_OVF_EN
        o = 1'b0;
`endif
        return {o, r < 0, 16'(r & mask)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for in_ready, presents one op for one accept edge.
    task automatic start_op(input int sel, input logic [15:0] x, input logic [15:0] y,
                            input logic z);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready[sel] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(in_ready[sel]), 32'd1);
        a = x;
        b = y;
        bin = z;
        in_valid[sel] = 1'b1;
        @(posedge clk);
        #1 in_valid[sel] = 1'b0;
    endtask

    // Called just after the accept edge; checks RUN entry, latency and result.
    task automatic wait_result(input int sel, input logic [15:0] x, input logic [15:0] y,
                               input logic z, input string tag);
        logic [17:0] e;
        int          lat;
        e   = model(width_of(sel), x, y, z);
        lat = 0;
        @(negedge clk);
        check({tag, "_run_valid"}, 32'(out_valid[sel]), 32'd0);
        check({tag, "_run_ready"}, 32'(in_ready[sel]), 32'd0);
        while (!out_valid[sel] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(steps_of(sel)));
        check({tag, "_diff"}, 32'(get_diff(sel)), 32'(e[15:0]));
        check({tag, "_bout"}, 32'(bout_v[sel]), 32'(e[16]));
        check({tag, "_ovf"}, 32'(ovf_v[sel]), 32'(e[17]));
    endtask

    task automatic release_out(input int sel, input string tag);
        @(negedge clk) out_ready[sel] = 1'b1;
        @(posedge clk);
        #1 out_ready[sel] = 1'b0;
        @(negedge clk);
        check({tag, "_drop_valid"}, 32'(out_valid[sel]), 32'd0);
        check({tag, "_idle_ready"}, 32'(in_ready[sel]), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  tbl [8];
        logic [16:0] q [$];
        logic [17:0] m;
        logic [16:0] e;
        logic [15:0] ca, cb, hold;
        logic        cz, exp_ovf;
        int          sent, got, cyc, dup;

        tbl = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};
        a = '0; b = '0; bin = 1'b0;
        in_valid = '0; out_ready = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state of every instance.
        for (int s = 0; s < 4; s++) begin
            check("rst_out_valid", 32'(out_valid[s]), 32'd0);
            check("rst_in_ready", 32'(in_ready[s]), 32'd1);
            check("rst_diff", 32'(get_diff(s)), 32'd0);
            check("rst_bout", 32'(bout_v[s]), 32'd0);
            check("rst_ovf", 32'(ovf_v[s]), 32'd0);
        end
        rst = 1'b0;

        // 1-bit exhaustive truth table.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            start_op(0, 16'(v[2]), 16'(v[1]), v[0]);
            wait_result(0, 16'(v[2]), 16'(v[1]), v[0], "w1");
            check("w1_table", 32'({bout_v[0], d1}), 32'(tbl[i]));
            release_out(0, "w1");
        end

        // 8x1: 5 - 3 = 2 in eight cycles.
        start_op(1, 16'h05, 16'h03, 1'b0);
        wait_result(1, 16'h05, 16'h03, 1'b0, "t2");
        check("t2_diff_const", 32'(d8), 32'h02);
        release_out(1, "t2");

        // 8x4: 0 - 1 wraps with borrow; 0x80 - 1 overflows when the flag is built in.
        start_op(2, 16'h00, 16'h01, 1'b0);
        wait_result(2, 16'h00, 16'h01, 1'b0, "t3a");
        check("t3a_diff_const", 32'(d84), 32'hFF);
        check("t3a_bout_const", 32'(bout_v[2]), 32'd1);
        release_out(2, "t3a");
`ifdef SERIAL_SUB_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        start_op(2, 16'h80, 16'h01, 1'b0);
        wait_result(2, 16'h80, 16'h01, 1'b0, "t3b");
        check("t3b_diff_const", 32'(d84), 32'h7F);
        check("t3b_ovf_const", 32'(ovf_v[2]), 32'(exp_ovf));
        release_out(2, "t3b");

        // A few random ops on the 8-bit geometries.
        for (int i = 0; i < 6; i++) begin
            ca = 16'($urandom); cb = 16'($urandom); cz = 1'($urandom_range(0, 1));
            start_op(2, ca, cb, cz);
            wait_result(2, ca, cb, cz, "rnd84");
            release_out(2, "rnd84");
            start_op(1, ca, cb, cz);
            wait_result(1, ca, cb, cz, "rnd8");
            release_out(1, "rnd8");
        end

        // Backpressure: hold result for 5 cycles, then handoff + accept together.
        start_op(1, 16'h3C, 16'h5A, 1'b1);
        wait_result(1, 16'h3C, 16'h5A, 1'b1, "t4a");
        hold = model(8, 16'h3C, 16'h5A, 1'b1) >> 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(out_valid[1]), 32'd1);
            check("t4_hold_diff", 32'(d8), 32'(hold[7:0]));
            check("t4_hold_ready", 32'(in_ready[1]), 32'd0);
        end
        @(negedge clk);
        out_ready[1] = 1'b1;
        a = 16'h91; b = 16'h27; bin = 1'b0;
        in_valid[1] = 1'b1;
        #1 check("t4_handoff_ready", 32'(in_ready[1]), 32'd1);
        @(posedge clk);
        #1 in_valid[1] = 1'b0;
        out_ready[1] = 1'b0;
        wait_result(1, 16'h91, 16'h27, 1'b0, "t4b");
        release_out(1, "t4b");

        // 16x1: 50 random back-to-back ops with random consumer stalls.
        sent = 0; got = 0; cyc = 0; dup = 0;
        ca = 16'($urandom); cb = 16'($urandom); cz = 1'($urandom_range(0, 1));
        while (got < 50 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            out_ready[3] = 1'($urandom_range(0, 1));
            in_valid[3]  = (sent < 50);
            a = ca; b = cb; bin = cz;
            #1;
            if (out_valid[3] && out_ready[3]) begin
                if (q.size() == 0) begin
                    dup++;
                end else begin
                    e = q.pop_front();
                    check("t5_diff", 32'(d16), 32'(e[15:0]));
                    check("t5_bout", 32'(bout_v[3]), 32'(e[16]));
                end
                got++;
            end
            if (in_valid[3] && in_ready[3]) begin
                m = model(16, ca, cb, cz);
                q.push_back(m[16:0]);
                sent++;
                ca = 16'($urandom); cb = 16'($urandom); cz = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        in_valid[3] = 1'b0;
        out_ready[3] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid[3]) dup++;
        end
        out_ready[3] = 1'b0;
        check("t5_results", 32'(got), 32'd50);
        check("t5_accepted", 32'(sent), 32'd50);
        check("t5_extra", 32'(dup), 32'd0);
        check("t5_left_over", 32'(q.size()), 32'd0);

        // Asynchronous reset in the middle of an 8-step op.
        start_op(1, 16'hAA, 16'h55, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_out_valid", 32'(out_valid[1]), 32'd0);
        check("t6_in_ready", 32'(in_ready[1]), 32'd1);
        check("t6_diff", 32'(d8), 32'd0);
        check("t6_bout", 32'(bout_v[1]), 32'd0);
        check("t6_ovf", 32'(ovf_v[1]), 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_no_result", 32'(out_valid[1]), 32'd0);
        start_op(1, 16'h10, 16'h01, 1'b0);
        wait_result(1, 16'h10, 16'h01, 1'b0, "t6");
        check("t6_diff_const", 32'(d8), 32'h0F);
        release_out(1, "t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
